// File: rtl/ip_pkg.sv
// rtl/ip_pkg.sv - shared types and sat/wrap reduction for the inner-product accumulate stage
//
// Purpose: accumulator state encoding, extended-sum width helper and the
// saturating/wrapping reduction used on both the chunk sum and the running sum.
// Ports: none (package).
package ip_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Width that holds a SIZE-lane sum of BITWIDTH-range values exactly.
  function automatic int sum_ext_w(input int bitwidth, input int size);
    return bitwidth + $clog2(size);
  endfunction

  // Reduces an exact value to the bw-bit range. The caller keeps the low bw
  // bits of the result, so a non-saturating reduction just passes v through
  // and truncation does the modulo wrap.
  function automatic logic signed [63:0] reduce_sum(
    input  logic signed [63:0] v,
    input  int                 bw,
    input  logic               sgn,
    input  logic               sat,
    output logic               ovf
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (sgn) begin
      hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bw - 1));
    end else begin
      hi = (64'sd1 <<< bw) - 64'sd1;
      lo = 64'sd0;
    end
    ovf = (v > hi) || (v < lo);
    if (sat && (v > hi)) begin
      return hi;
    end else if (sat && (v < lo)) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/ip_dot_pipe.sv
// rtl/ip_dot_pipe.sv - SIZE-lane dot product with optional register stage
//
// Purpose: per-chunk dot product (signed or unsigned lanes), reduction to
// BITWIDTH with a chunk overflow flag, and an optional register carrying
// {dot, ovf, last, valid} towards the accumulator.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   x, w              packed lane elements
//   load              beat accepted this cycle
//   last              accepted beat ends the vector
//   hold              downstream stalled, register holds
//   flush             drop register contents
//   dot, dot_ovf      reduced chunk sum and its overflow flag
//   dot_last          sideband last for the presented chunk
//   dot_valid         chunk presented to the accumulator
module ip_dot_pipe
  import ip_pkg::*;
#(
  parameter int BITWIDTH       = 16,
  parameter int INPUT_BITWIDTH = 8,
  parameter int SIZE           = 8,
  parameter int PIPE           = 1,
  parameter int SIGNED         = 1,
  parameter int SAT            = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INPUT_BITWIDTH*SIZE-1:0] x,
  input  logic [INPUT_BITWIDTH*SIZE-1:0] w,
  input  logic                           load,
  input  logic                           last,
  input  logic                           hold,
  input  logic                           flush,
  output logic [BITWIDTH-1:0]            dot,
  output logic                           dot_ovf,
  output logic                           dot_last,
  output logic                           dot_valid
);

  localparam int SUM_EXT = sum_ext_w(BITWIDTH, SIZE);
  localparam int PW      = 2 * INPUT_BITWIDTH;

  logic [INPUT_BITWIDTH-1:0] xe;
  logic [INPUT_BITWIDTH-1:0] we;
  logic [PW-1:0]             prod;
  logic signed [SUM_EXT-1:0] sum;
  logic signed [63:0]        sum64;
  logic [BITWIDTH-1:0]       dot_c;
  logic                      ovf_c;

  always_comb begin
    xe    = '0;
    we    = '0;
    prod  = '0;
    sum   = '0;
    ovf_c = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      xe = x[i*INPUT_BITWIDTH +: INPUT_BITWIDTH];
      we = w[i*INPUT_BITWIDTH +: INPUT_BITWIDTH];
      if (SIGNED != 0) begin
        prod = PW'($signed(xe)) * PW'($signed(we));
        sum  = sum + SUM_EXT'($signed(prod));
      end else begin
        prod = PW'(xe) * PW'(we);
        sum  = sum + SUM_EXT'(prod);
      end
    end
    if (SIGNED != 0) begin
      sum64 = 64'(sum);
    end else begin
      sum64 = 64'($unsigned(sum));
    end
    dot_c = BITWIDTH'(reduce_sum(sum64, BITWIDTH, SIGNED != 0, SAT != 0, ovf_c));
  end

  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dot       <= '0;
        dot_ovf   <= 1'b0;
        dot_last  <= 1'b0;
        dot_valid <= 1'b0;
      end else if (flush) begin
        dot_valid <= 1'b0;
      end else if (!hold) begin
        dot       <= dot_c;
        dot_ovf   <= ovf_c;
        dot_last  <= last;
        dot_valid <= load;
      end
    end
  end else begin : g_comb
    assign dot       = dot_c;
    assign dot_ovf   = ovf_c;
    assign dot_last  = last;
    assign dot_valid = load && !hold && !flush;
  end

endmodule

// File: rtl/ip_accum_stage.sv
// rtl/ip_accum_stage.sv - multi-chunk inner-product accumulate stage
//
// Purpose: accepts SIZE-lane chunks, accumulates their dot products until a
// last beat, then holds the completed sum on a valid/ready output.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      chunk handshake, in_last marks the final chunk
//   x, w                   packed lane elements
//   flush                  drop partial accumulation and pipe contents
//   out_valid/out_ready    result handshake
//   out_sum, out_ovf       completed dot product and sticky overflow
module ip_accum_stage
  import ip_pkg::*;
#(
  parameter int BITWIDTH       = 16,
  parameter int INPUT_BITWIDTH = 8,
  parameter int SIZE           = 8,
  parameter int PIPE           = 1,
  parameter int SIGNED         = 1,
  parameter int SAT            = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [INPUT_BITWIDTH*SIZE-1:0] x,
  input  logic [INPUT_BITWIDTH*SIZE-1:0] w,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BITWIDTH-1:0]            out_sum,
  output logic                           out_ovf
);

  state_t              state;
  logic [BITWIDTH-1:0] acc;
  logic                acc_ovf;

  logic                stall;
  logic                beat;
  logic                consume;
  logic [BITWIDTH-1:0] dot;
  logic                dot_ovf;
  logic                dot_last;
  logic                dot_valid;

  logic signed [63:0]  acc64;
  logic signed [63:0]  dot64;
  logic [BITWIDTH-1:0] run_sum;
  logic                run_ovf;
  logic [BITWIDTH-1:0] next_acc;
  logic                next_ovf;

  // A pending result that the consumer refuses freezes the whole stage.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign beat     = in_valid && !stall;
  assign consume  = dot_valid && !stall;

  ip_dot_pipe #(
    .BITWIDTH       (BITWIDTH),
    .INPUT_BITWIDTH (INPUT_BITWIDTH),
    .SIZE           (SIZE),
    .PIPE           (PIPE),
    .SIGNED         (SIGNED),
    .SAT            (SAT)
  ) u_dot (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .w         (w),
    .load      (beat),
    .last      (in_last),
    .hold      (stall),
    .flush     (flush),
    .dot       (dot),
    .dot_ovf   (dot_ovf),
    .dot_last  (dot_last),
    .dot_valid (dot_valid)
  );

  always_comb begin
    run_ovf = 1'b0;
    if (SIGNED != 0) begin
      acc64 = 64'($signed(acc));
      dot64 = 64'($signed(dot));
    end else begin
      acc64 = 64'(acc);
      dot64 = 64'(dot);
    end
    run_sum = BITWIDTH'(reduce_sum(acc64 + dot64, BITWIDTH, SIGNED != 0, SAT != 0, run_ovf));
    if (state == IDLE) begin
      next_acc = dot;
      next_ovf = dot_ovf;
    end else begin
      next_acc = run_sum;
      next_ovf = acc_ovf | dot_ovf | run_ovf;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      acc_ovf   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      // A result loading on the same edge below overrides this clear.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (flush) begin
        state   <= IDLE;
        acc     <= '0;
        acc_ovf <= 1'b0;
      end else if (consume) begin
        if (dot_last) begin
          out_sum   <= next_acc;
          out_ovf   <= next_ovf;
          out_valid <= 1'b1;
          state     <= IDLE;
          acc       <= '0;
          acc_ovf   <= 1'b0;
        end else begin
          acc     <= next_acc;
          acc_ovf <= next_ovf;
          state   <= ACCUM;
        end
      end
    end
  end

endmodule
